// File: rtl/core_param.sv
// core_param: accumulator core with a 16-bit instruction word, a small register
// file and req/ack instruction and data memory ports.
module core_param #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int NUM_REGS  = 8,
  parameter int CORE_ID_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CORE_ID_W-1:0] core_id,
  output logic                 im_req,
  output logic [ADDR_W-1:0]    im_addr,
  input  logic                 im_ack,
  input  logic [15:0]          im_rdata,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [ADDR_W-1:0]    dm_addr,
  output logic [DATA_W-1:0]    dm_wdata,
  input  logic                 dm_ack,
  input  logic [DATA_W-1:0]    dm_rdata,
  output logic                 halted,
  output logic [ADDR_W-1:0]    pc
);

  localparam int REG_AW = $clog2(NUM_REGS);

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_MVA = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_MUL = 4'h6;
  localparam logic [3:0] OP_LD  = 4'h7;
  localparam logic [3:0] OP_ST  = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_CID = 4'hB;
  localparam logic [3:0] OP_INC = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] ac;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [3:0]        op;
  logic [7:0]        imm;
  logic [REG_AW-1:0] rd_idx;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] mul_lo;

  // Register index wraps modulo NUM_REGS by dropping the upper rd bits.
  assign op     = ir[15:12];
  assign imm    = ir[7:0];
  assign rd_idx = REG_AW'(ir[11:8]);
  assign rd_val = regs[rd_idx];
  assign mul_lo = ac * rd_val;

  assign im_addr  = pc;
  assign dm_addr  = ADDR_W'(rd_val);
  assign dm_wdata = ac;
  assign halted   = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    im_req     = 1'b0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    case (state)
      FETCH: begin
        im_req = 1'b1;
        if (im_ack) next_state = EXEC;
      end
      EXEC: begin
        case (op)
          OP_LD, OP_ST: next_state = MEM;
          OP_HLT:       next_state = HALT;
          default:      next_state = FETCH;
        endcase
      end
      MEM: begin
        dm_req = 1'b1;
        dm_we  = (op == OP_ST);
        if (dm_ack) next_state = FETCH;
      end
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
    // Requests drop in the reset cycle so any ack arriving then is ignored.
    if (rst) begin
      im_req = 1'b0;
      dm_req = 1'b0;
      dm_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      ac <= '0;
      ir <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (im_ack) begin
            ir <= im_rdata;
            pc <= pc + ADDR_W'(1);
          end
        end
        EXEC: begin
          case (op)
            OP_LDI: ac <= DATA_W'(imm);
            OP_MOV: regs[rd_idx] <= ac;
            OP_MVA: ac <= rd_val;
            OP_ADD: ac <= ac + rd_val;
            OP_SUB: ac <= ac - rd_val;
            OP_MUL: ac <= mul_lo;
            OP_JMP: pc <= ADDR_W'(imm);
            OP_JZ:  if (ac == '0) pc <= ADDR_W'(imm);
            OP_CID: ac <= DATA_W'(core_id);
            OP_INC: regs[rd_idx] <= rd_val + DATA_W'(1);
            default: ;
          endcase
        end
        MEM: begin
          if (dm_ack && op == OP_LD) ac <= dm_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_param.sv
// Directed bench for core_param (DATA_W=8, ADDR_W=8, NUM_REGS=4) with
// req/ack memory models that insert programmable wait states.
module tb_core_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  core_id;
  logic        im_req;
  logic [7:0]  im_addr;
  logic        im_ack;
  logic [15:0] im_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [7:0]  dm_addr;
  logic [7:0]  dm_wdata;
  logic        dm_ack;
  logic [7:0]  dm_rdata;
  logic        halted;
  logic [7:0]  pc;

  core_param #(.DATA_W(8), .ADDR_W(8), .NUM_REGS(4), .CORE_ID_W(5)) dut (
    .clk(clk), .rst(rst), .core_id(core_id),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  assign core_id = 5'd19;

  logic [15:0] im_mem [256];
  logic [7:0]  dm_mem [256];
  logic [7:0]  fetch_log [1024];
  int          im_dly = 0;
  int          dm_dly = 0;
  int          im_cnt = 0;
  int          dm_cnt = 0;
  logic        dm_force = 1'b0;
  int          fetch_cnt = 0;
  int          wr_cnt = 0;
  logic [7:0]  last_wr_addr = 8'h00;
  logic [7:0]  last_wr_data = 8'h00;
  int          im_unstable = 0;
  int          dm_unstable = 0;
  logic        im_pend = 1'b0;
  logic        dm_pend = 1'b0;
  logic        dm_pend_we = 1'b0;
  logic [7:0]  im_pend_addr = 8'h00;
  logic [7:0]  dm_pend_addr = 8'h00;
  logic [7:0]  dm_pend_wdata = 8'h00;

  int errors = 0;
  int checks = 0;

  // Memory models: ack after a programmable number of wait cycles.
  assign im_rdata = im_mem[im_addr];
  assign im_ack   = im_req && (im_cnt >= im_dly);
  assign dm_ack   = (dm_req && (dm_cnt >= dm_dly)) || dm_force;
  assign dm_rdata = dm_mem[dm_addr];

  always @(posedge clk) begin
    im_cnt <= (im_req && !im_ack) ? im_cnt + 1 : 0;
    dm_cnt <= (dm_req && !dm_ack) ? dm_cnt + 1 : 0;
    if (im_req && im_ack) begin
      fetch_log[fetch_cnt % 1024] <= im_addr;
      fetch_cnt <= fetch_cnt + 1;
    end
    if (dm_req && dm_ack && dm_we) begin
      dm_mem[dm_addr] <= dm_wdata;
      last_wr_addr    <= dm_addr;
      last_wr_data    <= dm_wdata;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  // A pending request must hold its address/data until acknowledged.
  always @(negedge clk) begin
    if (!rst && im_pend && (!im_req || im_addr != im_pend_addr))
      im_unstable <= im_unstable + 1;
    if (!rst && dm_pend && (!dm_req || dm_addr != dm_pend_addr ||
                            dm_wdata != dm_pend_wdata || dm_we != dm_pend_we))
      dm_unstable <= dm_unstable + 1;
    im_pend       <= im_req && !im_ack;
    im_pend_addr  <= im_addr;
    dm_pend       <= dm_req && !dm_ack;
    dm_pend_addr  <= dm_addr;
    dm_pend_wdata <= dm_wdata;
    dm_pend_we    <= dm_we;
  end

  typedef struct {
    string           name;
    logic [7:0][15:0] code;
    int              im_dly;
    int              dm_dly;
    int              exp_cycles;
    logic [7:0]      exp_ac;
    int              exp_fetch;
    int              exp_wr;
    logic [7:0]      exp_wr_addr;
    logic [7:0]      exp_wr_data;
    logic [7:0]      exp_pc;
  } vec_t;

  function automatic logic [7:0][15:0] prog8(input logic [15:0] a, b, c, d, e, f, g, h);
    return {h, g, f, e, d, c, b, a};
  endfunction

  function automatic vec_t mkvec(input string name, input logic [7:0][15:0] code,
                                 input int imd, input int dmd, input int cyc,
                                 input logic [7:0] ac, input int fetches, input int wr,
                                 input logic [7:0] wa, input logic [7:0] wd,
                                 input logic [7:0] epc);
    vec_t v;
    v.name = name; v.code = code; v.im_dly = imd; v.dm_dly = dmd;
    v.exp_cycles = cyc; v.exp_ac = ac; v.exp_fetch = fetches; v.exp_wr = wr;
    v.exp_wr_addr = wa; v.exp_wr_data = wd; v.exp_pc = epc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) im_mem[i] = 16'hF000;
  endtask

  task automatic reset_core(input bit check);
    rst      = 1'b1;
    dm_force = 1'b0;
    repeat (2) @(negedge clk);
    if (check) begin
      checkOutput("rst_im_req", im_req, 0);
      checkOutput("rst_dm_req", dm_req, 0);
      checkOutput("rst_dm_we", dm_we, 0);
      checkOutput("rst_halted", halted, 0);
      checkOutput("rst_pc", pc, 0);
    end
    rst = 1'b0;
    if (check) begin
      #1;
      checkOutput("first_fetch_req", im_req, 1);
      checkOutput("first_fetch_addr", im_addr, 0);
    end
  endtask

  task automatic wait_halt(input string name, input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput({name, "_halted"}, halted, 1);
  endtask

  task automatic applyStimulus(input vec_t v, input bit first);
    int cyc, fb, wb, iu, du;
    clear_prog();
    for (int k = 0; k < 8; k++) im_mem[k] = v.code[k];
    im_dly = v.im_dly;
    dm_dly = v.dm_dly;
    fb = fetch_cnt; wb = wr_cnt; iu = im_unstable; du = dm_unstable;
    reset_core(first);
    wait_halt(v.name, 400, cyc);
    checkOutput({v.name, "_cycles"}, cyc, v.exp_cycles);
    checkOutput({v.name, "_ac"}, dut.ac, v.exp_ac);
    checkOutput({v.name, "_fetches"}, fetch_cnt - fb, v.exp_fetch);
    checkOutput({v.name, "_writes"}, wr_cnt - wb, v.exp_wr);
    if (v.exp_wr != 0) begin
      checkOutput({v.name, "_wr_addr"}, last_wr_addr, v.exp_wr_addr);
      checkOutput({v.name, "_wr_data"}, last_wr_data, v.exp_wr_data);
    end
    checkOutput({v.name, "_im_stable"}, im_unstable - iu, 0);
    checkOutput({v.name, "_dm_stable"}, dm_unstable - du, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({v.name, "_halt_pc"}, pc, v.exp_pc);
    checkOutput({v.name, "_halt_im_req"}, im_req, 0);
    checkOutput({v.name, "_halt_dm_req"}, dm_req, 0);
  endtask

  vec_t vecs [7];

  initial begin
    int cyc, fb, n;
    rst = 1'b1;
    clear_prog();

    vecs[0] = mkvec("zero_wait", prog8(16'h1005, 16'h2100, 16'h1003, 16'h6100,
                    16'hF000, 16'hF000, 16'hF000, 16'hF000), 0, 0, 10, 8'd15, 5, 0, 8'h00, 8'h00, 8'h05);
    vecs[1] = mkvec("im_wait3", prog8(16'h1005, 16'h2100, 16'h1003, 16'h6100,
                    16'hF000, 16'hF000, 16'hF000, 16'hF000), 3, 0, 25, 8'd15, 5, 0, 8'h00, 8'h00, 8'h05);
    vecs[2] = mkvec("mem_st_ld", prog8(16'h1010, 16'h2200, 16'h10AA, 16'h8200,
                    16'h1000, 16'h7200, 16'hF000, 16'hF000), 0, 2, 20, 8'hAA, 7, 1, 8'h10, 8'hAA, 8'h07);
    vecs[3] = mkvec("wrap_jz", prog8(16'h1001, 16'h2100, 16'h10FF, 16'h4100,
                    16'hA006, 16'h1077, 16'hF000, 16'hF000), 0, 0, 12, 8'h00, 6, 0, 8'h00, 8'h00, 8'h07);
    vecs[4] = mkvec("jz_fall", prog8(16'h1009, 16'h2100, 16'h1007, 16'h5100,
                    16'hA007, 16'hC100, 16'h3100, 16'hF000), 0, 0, 16, 8'h0A, 8, 0, 8'h00, 8'h00, 8'h08);
    vecs[5] = mkvec("cid_rdmod", prog8(16'hD5FF, 16'hB000, 16'h2600, 16'h1000,
                    16'h3200, 16'h8200, 16'hF000, 16'hF000), 0, 0, 15, 8'h13, 7, 1, 8'h13, 8'h13, 8'h07);
    vecs[6] = mkvec("jmp_mul", prog8(16'h1010, 16'h2300, 16'h1011, 16'h6300,
                    16'h9006, 16'h1099, 16'hF000, 16'hF000), 1, 0, 18, 8'h10, 6, 0, 8'h00, 8'h00, 8'h07);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i == 0);

    // Taken branch to 0x20: the fetch right after JZ must use the target.
    clear_prog();
    im_mem[0] = 16'h1000; im_mem[1] = 16'hA020; im_mem[8'h20] = 16'hF000;
    im_dly = 0; dm_dly = 0;
    fb = fetch_cnt;
    reset_core(1'b0);
    wait_halt("jz_far", 100, cyc);
    checkOutput("jz_far_fetches", fetch_cnt - fb, 3);
    checkOutput("jz_far_addr", fetch_log[(fb + 2) % 1024], 8'h20);
    checkOutput("jz_far_pc", pc, 8'h21);

    // PC wraps from 0xFF back to 0x00.
    clear_prog();
    im_mem[0] = 16'hA0FE; im_mem[8'hFE] = 16'h1042; im_mem[8'hFF] = 16'h0000;
    fb = fetch_cnt;
    reset_core(1'b0);
    wait_halt("pc_wrap", 100, cyc);
    checkOutput("pc_wrap_fetches", fetch_cnt - fb, 5);
    checkOutput("pc_wrap_addr", fetch_log[(fb + 3) % 1024], 8'h00);
    checkOutput("pc_wrap_ac", dut.ac, 8'h42);
    checkOutput("pc_wrap_pc", pc, 8'h02);

    // Reset in the middle of an LD with a same-cycle forced ack.
    clear_prog();
    im_mem[0] = 16'h1030; im_mem[1] = 16'h2200; im_mem[2] = 16'h1099;
    im_mem[3] = 16'h8200; im_mem[4] = 16'h1055; im_mem[5] = 16'h7200;
    fb = wr_cnt;
    reset_core(1'b0);
    n = 0;
    while (wr_cnt == fb && n < 50) begin @(posedge clk); #1; n++; end
    checkOutput("rstmem_store_seen", wr_cnt - fb, 1);
    dm_dly = 100;
    n = 0;
    while (!(dm_req && !dm_we) && n < 50) begin @(posedge clk); #1; n++; end
    checkOutput("rstmem_ld_req", dm_req, 1);
    rst = 1'b1;
    dm_force = 1'b1;
    #1;
    checkOutput("rstmem_dm_req_in_rst", dm_req, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dm_force = 1'b0;
    #1;
    checkOutput("rstmem_ac", dut.ac, 8'h00);
    checkOutput("rstmem_dm_req", dm_req, 0);
    checkOutput("rstmem_im_req", im_req, 1);
    checkOutput("rstmem_im_addr", im_addr, 8'h00);
    dm_dly = 0;
    wait_halt("rstmem_rerun", 100, cyc);
    checkOutput("rstmem_rerun_ac", dut.ac, 8'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
